// File: rtl/frogger_pkg.sv
// Shared constants for the Frogger car lanes: per-lane speeds, start
// positions, initial directions, FSM encoding and the lane Y rows used
// by Sprite_Display.
package frogger_pkg;

  typedef logic [1:0] lane_state_t;

  localparam lane_state_t ST_IDLE = 2'd0;
  localparam lane_state_t ST_LANE = 2'd1;
  localparam lane_state_t ST_DONE = 2'd2;

  // Lane n moves right when bit n is set.
  localparam logic [3:0] REVERSE_INIT = 4'b0101;

  // Screen rows of the four car lanes (top edge of the sprite).
  localparam logic [9:0] C_LINE_1_Y = 10'd96;
  localparam logic [9:0] C_LINE_2_Y = 10'd160;
  localparam logic [9:0] C_LINE_3_Y = 10'd224;
  localparam logic [9:0] C_LINE_4_Y = 10'd288;

  // Base speed of each lane in pixels per frame: {1,2,3,4}.
  function automatic logic [2:0] lane_speed(input logic [1:0] lane);
    case (lane)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      2'd2:    return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  // Start X of each lane: {0,160,320,480}.
  function automatic logic [9:0] init_x(input logic [1:0] lane);
    case (lane)
      2'd0:    return 10'd0;
      2'd1:    return 10'd160;
      2'd2:    return 10'd320;
      default: return 10'd480;
    endcase
  endfunction

endpackage

// File: rtl/lane_step.sv
// Combinational wrap-around stepper: moves X by step pixels in the given
// direction, keeping the result inside 0..SPAN-1.
module lane_step #(
  parameter int SPAN = 672
) (
  input  logic [9:0] x,
  input  logic [3:0] step,
  input  logic       dir,
  output logic [9:0] x_next
);

  localparam logic [10:0] SPAN_L = 11'(SPAN);

  logic [10:0] x_ext;
  logic [10:0] step_ext;
  logic [10:0] sum;

  assign x_ext    = {1'b0, x};
  assign step_ext = {7'd0, step};
  assign sum      = x_ext + step_ext;

  // Right moves wrap past SPAN-1 back to 0; left moves wrap below 0 to the far side.
  always_comb begin
    x_next = x;
    if (dir) begin
      if (sum >= SPAN_L) x_next = 10'(sum - SPAN_L);
      else               x_next = 10'(sum);
    end else begin
      if (x_ext < step_ext) x_next = 10'(x_ext + SPAN_L - step_ext);
      else                  x_next = 10'(x_ext - step_ext);
    end
  end

endmodule

// File: rtl/car_lane_controller.sv
// Per-frame car motion scheduler. At the start of vertical blanking it
// walks lanes 0..3 through a single shared stepper, one lane per cycle,
// then applies any pending level-up so a frame never mixes step sizes.
module car_lane_controller
  import frogger_pkg::*;
#(
  parameter int H_VISIBLE_AREA = 640,
  parameter int V_VISIBLE_AREA = 480,
  parameter int TILE_SIZE      = 32,
  parameter int MAX_LEVEL      = 7
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [9:0] i_H_Counter,
  input  logic [9:0] i_V_Counter,
  input  logic       i_Enable,
  input  logic       i_Level_Up,
  input  logic       i_Game_Reset,
  output logic [9:0] o_Car_1X_Position,
  output logic [9:0] o_Car_2X_Position,
  output logic [9:0] o_Car_3X_Position,
  output logic [9:0] o_Car_4X_Position,
  output logic [3:0] o_Reverse,
  output logic [2:0] o_Level,
  output logic       o_Frame_Done
);

  localparam int          SPAN        = H_VISIBLE_AREA + TILE_SIZE;
  localparam logic [9:0]  V_TICK_LINE = 10'(V_VISIBLE_AREA);
  localparam logic [2:0]  LEVEL_MAX   = 3'(MAX_LEVEL);

  lane_state_t state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [9:0]  pos_q [4];
  logic [9:0]  pos_d [4];
  logic [3:0]  reverse_q, reverse_d;
  logic [2:0]  level_q, level_d;
  logic        pending_q, pending_d;
  logic        done_q, done_d;

  logic        frame_tick;
  logic [3:0]  step;
  logic [9:0]  step_x;

  assign frame_tick = (i_H_Counter == 10'd0) && (i_V_Counter == V_TICK_LINE);
  assign step       = {1'b0, lane_speed(idx_q)} + {1'b0, level_q};

  lane_step #(.SPAN(SPAN)) u_lane_step (
    .x      (pos_q[idx_q]),
    .step   (step),
    .dir    (reverse_q[idx_q]),
    .x_next (step_x)
  );

  // Next-state logic: game reset first, then the IDLE/LANE/DONE walk.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pos_d     = pos_q;
    reverse_d = reverse_q;
    level_d   = level_q;
    pending_d = pending_q | i_Level_Up;
    done_d    = 1'b0;
    if (i_Game_Reset) begin
      state_d   = ST_IDLE;
      idx_d     = 2'd0;
      for (int n = 0; n < 4; n++) pos_d[n] = init_x(2'(n));
      reverse_d = REVERSE_INIT;
      level_d   = 3'd0;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_tick && i_Enable) begin
            state_d = ST_LANE;
            idx_d   = 2'd0;
          end
        end
        ST_LANE: begin
          pos_d[idx_q] = step_x;
          idx_d        = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ST_DONE;
        end
        ST_DONE: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          if (pending_d) begin
            pending_d = 1'b0;
            if (level_q < LEVEL_MAX) begin
              level_d   = level_q + 3'd1;
              reverse_d = ~reverse_q;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers; reset puts every lane back at its start position.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      for (int n = 0; n < 4; n++) pos_q[n] <= init_x(2'(n));
      reverse_q <= REVERSE_INIT;
      level_q   <= 3'd0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pos_q     <= pos_d;
      reverse_q <= reverse_d;
      level_q   <= level_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  assign o_Car_1X_Position = pos_q[0];
  assign o_Car_2X_Position = pos_q[1];
  assign o_Car_3X_Position = pos_q[2];
  assign o_Car_4X_Position = pos_q[3];
  assign o_Reverse         = reverse_q;
  assign o_Level           = level_q;
  assign o_Frame_Done      = done_q;

endmodule

// File: tb/tb_car_lane_controller.sv
// Directed bench for car_lane_controller: frame stepping, wrap-around,
// level-up timing and saturation, pause, and both reset paths.
module tb_car_lane_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       en;
  logic       lvl_up;
  logic       game_rst;
  logic [9:0] x1, x2, x3, x4;
  logic [3:0] rev;
  logic [2:0] level;
  logic       frame_done;

  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;
  int d0;

  always #5 clk = ~clk;

  car_lane_controller dut (
    .i_Clk             (clk),
    .i_Rst             (rst),
    .i_H_Counter       (h_cnt),
    .i_V_Counter       (v_cnt),
    .i_Enable          (en),
    .i_Level_Up        (lvl_up),
    .i_Game_Reset      (game_rst),
    .o_Car_1X_Position (x1),
    .o_Car_2X_Position (x2),
    .o_Car_3X_Position (x3),
    .o_Car_4X_Position (x4),
    .o_Reverse         (rev),
    .o_Level           (level),
    .o_Frame_Done      (frame_done)
  );

  // Count Frame_Done cycles, sampled mid-cycle.
  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int e0, input int e1, input int e2, input int e3);
    check({tag, ".x1"}, 32'(x1), 32'(e0));
    check({tag, ".x2"}, 32'(x2), 32'(e1));
    check({tag, ".x3"}, 32'(x3), 32'(e2));
    check({tag, ".x4"}, 32'(x4), 32'(e3));
    $display("[TB] %s: x = %0d %0d %0d %0d level=%0d rev=%b", tag, x1, x2, x3, x4, level, rev);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a frame tick sampled at the next edge k; returns 1 ns after k.
  task automatic tick_edge();
    @(negedge clk);
    h_cnt = 10'd0;
    v_cnt = 10'd480;
    @(posedge clk);
    #1;
    h_cnt = 10'd1;
    v_cnt = 10'd0;
  endtask

  task automatic frame();
    tick_edge();
    cyc(6);
  endtask

  task automatic pulse_game_reset();
    @(negedge clk);
    game_rst = 1'b1;
    @(negedge clk);
    game_rst = 1'b0;
  endtask

  task automatic pulse_level_up();
    @(negedge clk);
    lvl_up = 1'b1;
    @(negedge clk);
    lvl_up = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    h_cnt    = 10'd1;
    v_cnt    = 10'd0;
    en       = 1'b1;
    lvl_up   = 1'b0;
    game_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check_pos("reset", 0, 160, 320, 480);
    check("reset.rev", 32'(rev), 32'h5);
    check("reset.level", 32'(level), 0);
    check("reset.done", 32'(frame_done), 0);
    rst = 1'b0;

    // Basic step with exact lane timing
    tick_edge();
    check("basic.k.x1", 32'(x1), 0);
    cyc(1);
    check("basic.k1.x1", 32'(x1), 1);
    check("basic.k1.x2", 32'(x2), 160);
    cyc(1);
    check("basic.k2.x2", 32'(x2), 158);
    check("basic.k2.x3", 32'(x3), 320);
    cyc(2);
    check_pos("basic.k4", 1, 158, 323, 476);
    check("basic.k4.done", 32'(frame_done), 0);
    cyc(1);
    check("basic.k5.done", 32'(frame_done), 1);
    check("basic.k5.level", 32'(level), 0);
    check("basic.k5.rev", 32'(rev), 32'h5);
    cyc(1);
    check("basic.k6.done", 32'(frame_done), 0);

    // Wrap-around in both directions
    pulse_game_reset();
    repeat (80) frame();
    check("wrap.f80.x2", 32'(x2), 0);
    frame();
    check("wrap.f81.x2", 32'(x2), 670);
    check("wrap.f81.x1", 32'(x1), 81);
    repeat (36) frame();
    check("wrap.f117.x3", 32'(x3), 671);
    frame();
    check("wrap.f118.x3", 32'(x3), 2);
    repeat (553) frame();
    check("wrap.f671.x1", 32'(x1), 671);
    frame();
    check("wrap.f672.x1", 32'(x1), 0);

    // Level-up during lane 1: current frame keeps level-0 steps
    pulse_game_reset();
    tick_edge();
    cyc(1);
    lvl_up = 1'b1;
    cyc(1);
    lvl_up = 1'b0;
    cyc(2);
    check_pos("lvlmid.k4", 1, 158, 323, 476);
    check("lvlmid.k4.level", 32'(level), 0);
    cyc(1);
    check("lvlmid.k5.level", 32'(level), 1);
    check("lvlmid.k5.rev", 32'(rev), 32'hA);
    cyc(1);
    frame();
    check_pos("lvlmid.next", 671, 161, 319, 481);

    // Level saturation: 9 level-ups, one per frame
    pulse_game_reset();
    for (int i = 1; i <= 9; i++) begin
      pulse_level_up();
      frame();
      check($sformatf("sat.%0d.level", i), 32'(level), (i < 7) ? i : 7);
      check($sformatf("sat.%0d.rev", i), 32'(rev),
            (i >= 7) ? 32'hA : ((i % 2) == 1) ? 32'hA : 32'h5);
      $display("[TB] sat step %0d: level=%0d rev=%b", i, level, rev);
    end

    // Pause: tick ignored, then enable dropped mid-sequence
    pulse_game_reset();
    en = 1'b0;
    d0 = done_cnt;
    frame();
    check_pos("pause.ignored", 0, 160, 320, 480);
    check("pause.ignored.done", 32'(done_cnt), 32'(d0));
    en = 1'b1;
    tick_edge();
    en = 1'b0;
    cyc(4);
    check_pos("pause.midseq", 1, 158, 323, 476);
    cyc(2);
    check("pause.midseq.done", 32'(done_cnt), 32'(d0 + 1));
    en = 1'b1;

    // Async reset in lane index 2
    pulse_game_reset();
    tick_edge();
    cyc(2);
    check("rstmid.pre.x1", 32'(x1), 1);
    rst = 1'b1;
    #1;
    check_pos("rstmid.async", 0, 160, 320, 480);
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    cyc(6);
    check("rstmid.nodone", 32'(done_cnt), 32'(d0));
    check_pos("rstmid.idle", 0, 160, 320, 480);
    frame();
    check_pos("rstmid.next", 1, 158, 323, 476);

    // Game reset coinciding with a tick
    @(negedge clk);
    h_cnt    = 10'd0;
    v_cnt    = 10'd480;
    game_rst = 1'b1;
    @(posedge clk);
    #1;
    h_cnt    = 10'd1;
    v_cnt    = 10'd0;
    game_rst = 1'b0;
    check_pos("grtick", 0, 160, 320, 480);
    d0 = done_cnt;
    cyc(6);
    check("grtick.nodone", 32'(done_cnt), 32'(d0));
    check("grtick.x1", 32'(x1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
